// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - mid-bit sampling serial frame receiver with one-word holding register
// Optional even-parity bit enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              done_good;
  logic              done_ferr;
  logic              tick;

  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign tick = (state == START) ? (clk_cnt == HALF_LAST) : (clk_cnt == FULL_LAST);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bit;
  logic done_perr;
  logic perr;
  assign perr = par_bit ^ (^shift);
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      done_good <= 1'b0;
      done_ferr <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bit    <= 1'b0;
      done_perr  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done_good <= 1'b0;
      done_ferr <= 1'b0;
      busy      <= (state != IDLE);
      frame_err <= done_ferr;
      overrun   <= done_good && out_valid && !out_ready;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      done_perr  <= 1'b0;
      parity_err <= done_perr;
`endif
      // Delivery happens one edge after the stop sample; a drain in that cycle frees the slot.
      if (done_good && (!out_valid || out_ready)) begin
        out_data  <= shift;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      clk_cnt <= tick ? '0 : clk_cnt + 1'b1;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!s_in) state <= START;
        end
        START: if (tick) begin
          bit_cnt <= '0;
          state   <= s_in ? IDLE : DATA;
        end
        DATA: if (tick) begin
          shift   <= DATA_W'({s_in, shift} >> 1);
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: if (tick) begin
          par_bit <= s_in;
          state   <= STOP;
        end
`endif
        STOP: if (tick) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          done_perr <= perr;
          done_good <= s_in && !perr;
`else
          done_good <= s_in;
`endif
          done_ferr <= !s_in;
          state     <= s_in ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          clk_cnt <= '0;
          if (s_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - frame-level reference model bench for serial_frame_rx
// Parity scenarios are included when SERIAL_FRAME_RX_PARITY_EN is defined.
module tb_serial_frame_rx;

  localparam int D = 8;
  localparam int C = 4;
  localparam int H = C / 2;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int MAXC = 16384;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_in = 1'b1;
  logic [D-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  serial_frame_rx #(.DATA_W(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .s_in(s_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  // Expected events, indexed by the clock edge at which they must appear.
  bit           ev_good [MAXC];
  bit           ev_ferr [MAXC];
  bit           ev_perr [MAXC];
  logic [D-1:0] ev_word [MAXC];
  bit           busy_exp [MAXC];

  bit           chk_en = 1'b0;
  int           rdy_mode = 0;
  int           pulse_edge = -1;
  bit           rdy_q = 1'b0;
  bit           m_valid = 1'b0;
  logic [D-1:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e_ovr;
    if (chk_en && edge_n < MAXC) begin
      e_ovr = 1'b0;
      if (ev_good[edge_n]) begin
        if (!m_valid || rdy_q) begin
          m_valid = 1'b1;
          m_data  = ev_word[edge_n];
        end else begin
          e_ovr = 1'b1;
        end
      end else if (m_valid && rdy_q) begin
        m_valid = 1'b0;
      end
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) check("out_data", 32'(out_data), 32'(m_data));
      check("busy", 32'(busy), 32'(busy_exp[edge_n]));
      check("frame_err", 32'(frame_err), 32'(ev_ferr[edge_n]));
      check("parity_err", 32'(parity_err), 32'(ev_perr[edge_n]));
      check("overrun", 32'(overrun), 32'(e_ovr));
    end
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (edge_n + 1 == pulse_edge);
    endcase
    rdy_q = out_ready;
  end

  task automatic line(input logic v, input int n);
    s_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int e = a; e <= b; e++) if (e < MAXC) busy_exp[e] = 1'b1;
  endtask

  function automatic int deliver_edge(input int t);
    return t + H + (D + 1 + P) * C + 1;
  endfunction

  // Start is first seen at edge t; the verdict for the frame lands at edge e.
  task automatic send_frame(input logic [D-1:0] w, input bit par_good, input bit stop, input int extra_low);
    int  t, s, e, wi;
    bit  pb, perr;
    t    = edge_n + 1;
    e    = deliver_edge(t);
    s    = e - 1;
    pb   = (^w) ^ !par_good;
    perr = (P == 1) && !par_good;
    if (e < MAXC) begin
      ev_perr[e] = perr;
      if (stop) begin
        ev_good[e] = !perr;
        ev_word[e] = w;
      end else begin
        ev_ferr[e] = 1'b1;
      end
    end
    wi = t + (D + 2 + P) * C + extra_low;
    mark_busy(t + 1, stop ? s : wi);
    line(1'b0, C);
    for (int k = 0; k < D; k++) line(w[k], C);
    if (P == 1) line(pb, C);
    if (stop) line(1'b1, C);
    else      line(1'b0, C + extra_low);
  endtask

  task automatic glitch(input int len);
    int t;
    t = edge_n + 1;
    mark_busy(t + 1, t + H);
    line(1'b0, len);
    line(1'b1, H + 2);
  endtask

  initial begin
    int r;
    logic [D-1:0] w;
    s_in = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    rdy_mode = 1;
    line(1'b1, 3);

    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("a5_valid", 32'(out_valid), 32'd1);
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_busy_fall", 32'(busy), 32'd0);
    line(1'b1, 3);

    glitch(1);
    line(1'b1, 4);
    send_frame(8'h5A, 1'b1, 1'b0, 9 * C);
    line(1'b1, 4);

    rdy_mode = 0;
    send_frame(8'h11, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    check("bp_held_data", 32'(out_data), 32'h11);
    check("bp_overrun", 32'(overrun), 32'd1);
    line(1'b1, 3);
    rdy_mode = 1;
    line(1'b1, 3);
    send_frame(8'h33, 1'b1, 1'b1, 0);
    line(1'b1, 3);

    rdy_mode = 0;
    send_frame(8'h11, 1'b1, 1'b1, 0);
    line(1'b1, 2);
    pulse_edge = deliver_edge(edge_n + 1);
    rdy_mode = 3;
    send_frame(8'h44, 1'b1, 1'b1, 0);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_data", 32'(out_data), 32'h44);
    check("sim_overrun", 32'(overrun), 32'd0);
    rdy_mode = 1;
    line(1'b1, 3);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_ok_data", 32'(out_data), 32'h07);
    line(1'b1, 3);
    send_frame(8'h07, 1'b0, 1'b1, 0);
    check("par_bad_pulse", 32'(parity_err), 32'd1);
    check("par_bad_valid", 32'(out_valid), 32'd0);
    line(1'b1, 3);
`endif

    rdy_mode = 0;
    send_frame(8'h99, 1'b1, 1'b1, 0);
    line(1'b1, 2);
    chk_en = 1'b0;
    line(1'b0, C + H + 2 * C);
    s_in = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_valid = 1'b0;
    chk_en = 1'b1;
    rdy_mode = 1;
    line(1'b1, 3);
    send_frame(8'h3C, 1'b1, 1'b1, 0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h3C);
    line(1'b1, 2);

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      w = D'($urandom);
      if (r < 6) begin
        send_frame(w, 1'b1, 1'b1, 0);
      end else if (r == 6) begin
        send_frame(w, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 3 * C)));
        line(1'b1, 2);
      end else if (r == 7) begin
        send_frame(w, 1'b0, 1'b1, 0);
      end else begin
        glitch(int'($urandom_range(1, H)));
      end
      line(1'b1, int'($urandom_range(0, 4)));
    end
    rdy_mode = 1;
    line(1'b1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
